// File: rtl/cla_pkg.sv
// Shared constants and configuration check for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned GRP_W      = 4;
  localparam int unsigned MAX_STAGES = 8;

  // WIDTH must split into STAGES whole segments, each made of whole 4-bit lookahead groups.
  function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && (width > 0) &&
           ((width % (GRP_W * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_seg.sv
// Combinational SEG_W-bit carry-lookahead segment (module cla_seg): 4-bit g/p groups
// with a group-level lookahead producing every group carry directly from cin.
module cla_seg
  import cla_pkg::*;
#(
  parameter int unsigned SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] s_o,
  output logic             cout_o
);

  localparam int unsigned NG = SEG_W / GRP_W;

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    for (int unsigned j = 0; j < NG; j++) begin
      gg[j] = g[j*GRP_W+3]
            | (p[j*GRP_W+3] & g[j*GRP_W+2])
            | (p[j*GRP_W+3] & p[j*GRP_W+2] & g[j*GRP_W+1])
            | (p[j*GRP_W+3] & p[j*GRP_W+2] & p[j*GRP_W+1] & g[j*GRP_W]);
      gp[j] = &p[j*GRP_W +: GRP_W];
    end
  end

  // Each group carry is the OR of every lower generate qualified by the propagates above it.
  always_comb begin
    logic acc;
    logic pr;
    acc   = 1'b0;
    pr    = 1'b1;
    gc    = '0;
    gc[0] = cin_i;
    for (int unsigned j = 1; j <= NG; j++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int unsigned i = j; i > 0; i--) begin
        acc = acc | (pr & gg[i-1]);
        pr  = pr & gp[i-1];
      end
      gc[j] = acc | (pr & cin_i);
    end
  end

  always_comb begin
    c = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      c[j*GRP_W]   = gc[j];
      c[j*GRP_W+1] = g[j*GRP_W] | (p[j*GRP_W] & gc[j]);
      c[j*GRP_W+2] = g[j*GRP_W+1]
                   | (p[j*GRP_W+1] & g[j*GRP_W])
                   | (p[j*GRP_W+1] & p[j*GRP_W] & gc[j]);
      c[j*GRP_W+3] = g[j*GRP_W+2]
                   | (p[j*GRP_W+2] & g[j*GRP_W+1])
                   | (p[j*GRP_W+2] & p[j*GRP_W+1] & g[j*GRP_W])
                   | (p[j*GRP_W+2] & p[j*GRP_W+1] & p[j*GRP_W] & gc[j]);
    end
  end

  assign s_o    = p ^ c;
  assign cout_o = gc[NG];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, STAGES segments with valid/ready flow.
// Define CLA_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CLA_OVF_FLAG_EN
  output logic [WIDTH:0]   sum,
  output logic             ovf
`else
  output logic [WIDTH:0]   sum
`endif
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES and STAGES in 1..8");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // Inputs presented to stage k: the raw beat for k=0, otherwise stage k-1's registers.
  logic [STAGES-1:0] stg_v;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_r [STAGES];
  logic [STAGES-1:0] stg_c;

  logic [WIDTH-1:0]  res_d [STAGES];
  logic [STAGES-1:0] cy_d;

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [STAGES-1:0] cy_q;

  logic [STAGES:0]   rdy;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

    logic [SEG-1:0] seg_s;
    logic           seg_co;

    if (k == 0) begin : g_head
      assign stg_v[k] = in_valid;
      assign stg_a[k] = a;
      assign stg_b[k] = b_eff;
      assign stg_r[k] = '0;
      assign stg_c[k] = c_eff;
    end else begin : g_link
      assign stg_v[k] = vld_q[k-1];
      assign stg_a[k] = a_q[k-1];
      assign stg_b[k] = b_q[k-1];
      assign stg_r[k] = res_q[k-1];
      assign stg_c[k] = cy_q[k-1];
    end

    cla_seg #(
      .SEG_W (SEG)
    ) u_seg (
      .a_i    (stg_a[k][k*SEG +: SEG]),
      .b_i    (stg_b[k][k*SEG +: SEG]),
      .cin_i  (stg_c[k]),
      .s_o    (seg_s),
      .cout_o (seg_co)
    );

    // Lower result bits ride along with the beat; this stage fills in its own slice.
    assign res_d[k] = (stg_r[k] & ~SEG_MASK) | (WIDTH'(seg_s) << (k * SEG));
    assign cy_d[k]  = seg_co;
  end

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[STAGES-1-i] = !vld_q[STAGES-1-i] || rdy[STAGES-i];
    end
  end

  assign in_ready = rdy[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld_q[i] <= stg_v[i];
          a_q[i]   <= stg_a[i];
          b_q[i]   <= stg_b[i];
          res_q[i] <= res_d[i];
          cy_q[i]  <= cy_d[i];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = {cy_q[STAGES-1], res_q[STAGES-1]};

`ifdef CLA_OVF_FLAG_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (stg_a[STAGES-1][WIDTH-1] == stg_b[STAGES-1][WIDTH-1]) &&
                 (res_d[STAGES-1][WIDTH-1] != stg_a[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (rdy[STAGES-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vectors, random stream, backpressure, reset.
module tb_cla_pipe_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned ST = 2;
`ifdef CLA_OVF_FLAG_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
`ifdef CLA_OVF_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_sum_q [$];
  bit         exp_ovf_q [$];

  always #5 clk = ~clk;

  cla_pipe_adder #(
    .WIDTH  (W),
    .STAGES (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CLA_OVF_FLAG_EN
    .sum       (sum),
    .ovf       (ovf)
`else
    .sum       (sum)
`endif
  );

  // Reference: a+b+cin, or a-b offset by 2^W so the top bit reads as not-borrow.
  function automatic logic [W:0] model_sum(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
    longint r;
    if (ms) r = longint'(ma) - longint'(mb) + (longint'(1) << W);
    else    r = longint'(ma) + longint'(mb) + longint'(mc);
    return r[W:0];
  endfunction

  function automatic bit model_ovf(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
    longint sa, sb, r, hi, lo;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    r  = ms ? (sa - sb) : (sa + sb + longint'(mc));
    return OVF_ON && ((r > hi) || (r < lo));
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_beat();
    a   = rand_word();
    b   = rand_word();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // One clock: sample handshakes mid-cycle, track the model queue, advance to just after the edge.
  task automatic step(output bit in_fire, output bit out_fire, output bit unexp,
                      output logic [W:0] osum, output logic [W:0] esum,
                      output bit oovf, output bit eovf);
    #1;
    in_fire  = !rst && in_valid && in_ready;
    out_fire = !rst && out_valid && out_ready;
    osum     = sum;
    esum     = '0;
    unexp    = 1'b0;
    eovf     = 1'b0;
`ifdef CLA_OVF_FLAG_EN
    oovf     = ovf;
`else
    oovf     = 1'b0;
`endif
    if (out_fire) begin
      if (exp_sum_q.size() == 0) begin
        unexp = 1'b1;
      end else begin
        esum = exp_sum_q.pop_front();
        eovf = exp_ovf_q.pop_front();
      end
    end
    if (in_fire) begin
      exp_sum_q.push_back(model_sum(a, b, cin, sub));
      exp_ovf_q.push_back(model_ovf(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ifr, ofr, ux, oo, eo;
    logic [W:0] os, es;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(ifr, ofr, ux, os, es, oo, eo);
    step(ifr, ofr, ux, os, es, oo, eo);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef CLA_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic         vs;
    logic [W:0]   vsum;
    bit           vovf;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [9];
    bit ifr, ofr, ux, oo, eo, got;
    logic [W:0] os, es;
    int lat;
    tbl = '{
      '{32'h0000_0000, 32'h0001_1001, 1'b0, 1'b0, 33'h0_0001_1001, 1'b0},
      '{32'h0002_1001, 32'h0002_1001, 1'b0, 1'b0, 33'h0_0004_2002, 1'b0},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 1'b0},
      '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 1'b0},
      '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 33'h1_0000_0002, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000, 1'b0},
      '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0001_0000, 1'b0},
      '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1},
      '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 33'h1_7FFF_FFFF, 1'b1}
    };
    out_ready = 1'b1;
    for (int unsigned v = 0; v < 9; v++) begin
      a = tbl[v].va; b = tbl[v].vb; cin = tbl[v].vc; sub = tbl[v].vs;
      in_valid = 1'b1;
      step(ifr, ofr, ux, os, es, oo, eo);
      in_valid = 1'b0;
      checks++;
      if (!ifr) begin errors++; $display("FAIL directed%0d_accept got %b want 1", v, ifr); end
      lat = 1; got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        step(ifr, ofr, ux, os, es, oo, eo);
        if (ofr) got = 1'b1;
        else     lat++;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL directed%0d_timeout got no out_valid want one within 20 cycles", v);
      end else begin
        if (lat != ST) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", v, lat, ST); end
        checks++;
        if ({oo, os} !== {OVF_ON & tbl[v].vovf, tbl[v].vsum}) begin
          errors++;
          $display("FAIL directed%0d_sum got ovf=%b sum=%h want ovf=%b sum=%h",
                   v, oo, os, OVF_ON & tbl[v].vovf, tbl[v].vsum);
        end
      end
    end
  endtask

  task automatic test_stream();
    bit ifr, ofr, ux, oo, eo;
    logic [W:0] os, es;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    randomize_beat();
    while ((sent < 100 || exp_sum_q.size() > 0) && cyc < 3000) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      step(ifr, ofr, ux, os, es, oo, eo);
      if (ifr) begin sent++; randomize_beat(); end
      if (ofr) begin
        rcvd++;
        checks++;
        if (ux) begin
          errors++; $display("FAIL stream_extra got sum=%h want no beat", os);
        end else if ({oo, os} !== {eo, es}) begin
          errors++; $display("FAIL stream_beat%0d got ovf=%b sum=%h want ovf=%b sum=%h", rcvd, oo, os, eo, es);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout got %0d cycles want below 3000", cyc); end
    checks++;
    if (rcvd != 100) begin errors++; $display("FAIL stream_count got %0d want 100", rcvd); end
  endtask

  task automatic test_backpressure();
    bit ifr, ofr, ux, oo, eo, got_all;
    logic [W:0] os, es;
    int acc;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_beat();
    for (int unsigned i = 0; i < 5; i++) begin
      step(ifr, ofr, ux, os, es, oo, eo);
      if (ifr) begin acc++; randomize_beat(); end
      if (i >= ST - 1) begin
        checks++;
        if (out_valid !== 1'b1 || exp_sum_q.size() == 0 || sum !== exp_sum_q[0]) begin
          errors++; $display("FAIL stall_hold%0d got v=%b sum=%h want v=1 sum=oldest", i, out_valid, sum);
        end
      end
    end
    checks++;
    if (acc != ST) begin errors++; $display("FAIL stall_accepts got %0d want %0d", acc, ST); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    step(ifr, ofr, ux, os, es, oo, eo);
    checks++;
    if (!(ifr && ofr)) begin errors++; $display("FAIL full_push_pop got in=%b out=%b want 1 1", ifr, ofr); end
    checks++;
    if (ux || {oo, os} !== {eo, es}) begin
      errors++; $display("FAIL full_pop_value got ovf=%b sum=%h want ovf=%b sum=%h", oo, os, eo, es);
    end
    in_valid = 1'b0;
    got_all = 1'b0;
    for (int n = 0; n < 20 && !got_all; n++) begin
      step(ifr, ofr, ux, os, es, oo, eo);
      if (ofr) begin
        checks++;
        if (ux || {oo, os} !== {eo, es}) begin
          errors++; $display("FAIL drain_value got ovf=%b sum=%h want ovf=%b sum=%h", oo, os, eo, es);
        end
      end
      if (exp_sum_q.size() == 0) got_all = 1'b1;
    end
    checks++;
    if (!got_all) begin errors++; $display("FAIL drain_left got %0d beats want 0", exp_sum_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ifr, ofr, ux, oo, eo;
    logic [W:0] os, es;
    int rcvd, early;
    rcvd = 0; early = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int unsigned i = 0; i < 30 + ST + 2; i++) begin
      if (i == 30) in_valid = 1'b0;
      if (in_valid) randomize_beat();
      step(ifr, ofr, ux, os, es, oo, eo);
      if (i < 30) begin
        checks++;
        if (!ifr) begin errors++; $display("FAIL b2b_accept%0d got %b want 1", i, ifr); end
      end
      if (ofr) begin
        rcvd++;
        if (i < 30) early++;
        checks++;
        if (ux || {oo, os} !== {eo, es}) begin
          errors++; $display("FAIL b2b_beat%0d got ovf=%b sum=%h want ovf=%b sum=%h", rcvd, oo, os, eo, es);
        end
      end
    end
    checks++;
    if (early != 30 - ST) begin errors++; $display("FAIL b2b_throughput got %0d want %0d", early, 30 - ST); end
    checks++;
    if (rcvd != 30) begin errors++; $display("FAIL b2b_count got %0d want 30", rcvd); end
  endtask

  task automatic test_reset_mid();
    bit ifr, ofr, ux, oo, eo;
    logic [W:0] os, es;
    int stray;
    stray = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_beat();
    step(ifr, ofr, ux, os, es, oo, eo);
    randomize_beat();
    step(ifr, ofr, ux, os, es, oo, eo);
    in_valid = 1'b0;
    rst = 1'b1;
    step(ifr, ofr, ux, os, es, oo, eo);
    rst = 1'b0;
    exp_sum_q.delete();
    exp_ovf_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      step(ifr, ofr, ux, os, es, oo, eo);
      if (ofr) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midrst_stale got %0d beats want 0", stray); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
